// File: rtl/mat_mult_seq.sv
// Sequential NxN matrix multiplier: one multiply-accumulate per cycle over N^3 cycles,
// with operand and result valid/ready handshakes.
module mat_mult_seq #(
    parameter  int N      = 2,
    parameter  int DW     = 4,
    parameter  int SIGNED = 0,
    localparam int OW     = 2*DW + $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N*N*DW-1:0] a_in,
    input  logic [N*N*DW-1:0] b_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N*N*OW-1:0] c_out,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N-1);

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [DW-1:0]      r_a    [N][N];
    logic [DW-1:0]      r_b    [N][N];
    logic [OW-1:0]      r_work [N][N];
    logic [CW-1:0]      r_i, r_j, r_k;
    logic [OW-1:0]      r_acc;
    logic [N*N*OW-1:0]  r_c;

    logic [DW-1:0]      w_a, w_b;
    logic [2*DW-1:0]    w_a2, w_b2, w_prod;
    logic [OW-1:0]      w_prod_ext;
    logic [OW-1:0]      w_acc_next;
    logic               w_k_last, w_j_last, w_i_last, w_mac_last;
    logic               w_accept;

    assign w_a = r_a[r_i][r_k];
    assign w_b = r_b[r_k][r_j];

    // Operands widened to 2*DW so a single 2*DW multiply yields the exact product.
    generate
        if (SIGNED != 0) begin : g_signed
            assign w_a2       = {{DW{w_a[DW-1]}}, w_a};
            assign w_b2       = {{DW{w_b[DW-1]}}, w_b};
            assign w_prod_ext = OW'($signed(w_prod));
        end else begin : g_unsigned
            assign w_a2       = {{DW{1'b0}}, w_a};
            assign w_b2       = {{DW{1'b0}}, w_b};
            assign w_prod_ext = OW'(w_prod);
        end
    endgenerate

    assign w_prod     = w_a2 * w_b2;
    assign w_acc_next = ((r_k == '0) ? '0 : r_acc) + w_prod_ext;

    assign w_k_last   = (r_k == LAST);
    assign w_j_last   = (r_j == LAST);
    assign w_i_last   = (r_i == LAST);
    assign w_mac_last = w_k_last && w_j_last && w_i_last;

    // State alone is IDLE during reset, so gate with reset to keep in_ready low.
    assign in_ready  = (r_state == S_IDLE) && !reset;
    assign out_valid = (r_state == S_DONE);
    assign c_out     = r_c;
    assign w_accept  = in_valid && in_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept)   w_state_next = S_COMPUTE;
            S_COMPUTE: if (w_mac_last) w_state_next = S_DONE;
            S_DONE:    if (out_ready)  w_state_next = S_IDLE;
            default:                   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_acc <= '0;
            r_c   <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_a[r][c]    <= '0;
                    r_b[r][c]    <= '0;
                    r_work[r][c] <= '0;
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_i <= '0;
                        r_j <= '0;
                        r_k <= '0;
                        for (int r = 0; r < N; r++) begin
                            for (int c = 0; c < N; c++) begin
                                r_a[r][c] <= a_in[(r*N+c)*DW +: DW];
                                r_b[r][c] <= b_in[(r*N+c)*DW +: DW];
                            end
                        end
                    end
                end
                S_COMPUTE: begin
                    r_acc <= w_acc_next;
                    if (w_k_last) begin
                        r_work[r_i][r_j] <= w_acc_next;
                        r_k <= '0;
                        if (w_j_last) begin
                            r_j <= '0;
                            r_i <= w_i_last ? '0 : r_i + 1'b1;
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                    // The last element is still in flight, so it bypasses the working bank.
                    if (w_mac_last) begin
                        for (int r = 0; r < N; r++) begin
                            for (int c = 0; c < N; c++) begin
                                r_c[(r*N+c)*OW +: OW] <= (r == N-1 && c == N-1) ?
                                                         w_acc_next : r_work[r][c];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
